// File: rtl/serial_word_feeder.sv
// Parallel-in, serial-out feeder: accepts WIDTH-bit words on a valid/ready
// handshake and streams them one bit per clock with no gap between words.
module serial_word_feeder #(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter int IDLE_LEVEL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_bit;
   logic             accept;

   // Handshake: a word transfers on a rising edge where load_valid and
   // load_ready are both high; load_ready never depends on load_valid, and the
   // producer holds load_data/load_valid steady until that edge.
   assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
   assign load_ready = !rst && ((state_q == IDLE) || last_bit);
   assign accept     = load_valid && load_ready;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (accept) begin
         // Reload wins over the final shift so the next word follows at once.
         state_d = SHIFT;
         shreg_d = load_data;
         cnt_d   = '0;
      end else if (state_q == SHIFT) begin
         if (MSB_FIRST != 0) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
         end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
         end
         if (last_bit) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output mux uses registered state only; no input reaches serial_out.
   always_comb begin
      serial_out = (IDLE_LEVEL != 0);
      if (state_q == SHIFT) begin
         serial_out = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
      end
   end

   assign serial_valid = (state_q == SHIFT);
   assign busy         = (state_q == SHIFT);
   assign word_done    = last_bit;

endmodule
